// File: rtl/cv32e40p_fpu_rob.sv
// In-order result buffer for FPnew results on the X-interface offload path.
// Entries are reserved at issue, filled out of order by tag, and retired from the head in issue order.
module cv32e40p_fpu_rob #(
    parameter int FLEN      = 32,
    parameter int DEPTH     = 4,
    parameter int ID_WIDTH  = 4,
    parameter int TAG_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 alloc_valid_i,
    output logic                 alloc_ready_o,
    input  logic [ID_WIDTH-1:0]  alloc_id_i,
    input  logic [4:0]           alloc_rd_i,
    input  logic                 alloc_we_i,
    output logic [TAG_WIDTH-1:0] alloc_tag_o,
    input  logic                 fpu_valid_i,
    output logic                 fpu_ready_o,
    input  logic [TAG_WIDTH-1:0] fpu_tag_i,
    input  logic [FLEN-1:0]      fpu_result_i,
    input  logic [4:0]           fpu_status_i,
    input  logic                 flush_i,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic [ID_WIDTH-1:0]  result_id_o,
    output logic [4:0]           result_rd_o,
    output logic                 result_we_o,
    output logic [FLEN-1:0]      result_data_o,
    output logic [4:0]           result_fflags_o,
    output logic [TAG_WIDTH:0]   occupancy_o,
    output logic                 err_o
);

    localparam logic [1:0] S_FREE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [TAG_WIDTH:0] L_FULL = (TAG_WIDTH+1)'(DEPTH);

    logic [1:0]           r_state  [DEPTH];
    logic                 r_killed [DEPTH];
    logic [ID_WIDTH-1:0]  r_id     [DEPTH];
    logic [4:0]           r_rd     [DEPTH];
    logic                 r_we     [DEPTH];
    logic [FLEN-1:0]      r_data   [DEPTH];
    logic [4:0]           r_fflags [DEPTH];

    logic [TAG_WIDTH-1:0] r_head;
    logic [TAG_WIDTH-1:0] r_tail;
    logic [TAG_WIDTH:0]   r_count;
    logic                 r_err;

    logic                 w_alloc;
    logic                 w_wb_ok;
    logic                 w_wb_bad;
    logic                 w_head_done;
    logic                 w_head_valid;
    logic                 w_retire;
    logic                 w_drain;
    logic                 w_free_head;
    logic [TAG_WIDTH:0]   w_count_nxt;

    assign alloc_ready_o = (r_count != L_FULL);
    assign alloc_tag_o   = r_tail;
    assign fpu_ready_o   = 1'b1;
    assign occupancy_o   = r_count;
    assign err_o         = r_err;

    // Tail is always FREE when not full, so allocate never collides with writeback or retire.
    assign w_alloc      = alloc_valid_i && alloc_ready_o;
    assign w_wb_ok      = fpu_valid_i && (r_state[fpu_tag_i] == S_PEND);
    assign w_wb_bad     = fpu_valid_i && (r_state[fpu_tag_i] != S_PEND);
    assign w_head_done  = (r_state[r_head] == S_DONE);
    assign w_head_valid = w_head_done && !r_killed[r_head];
    assign w_retire     = w_head_valid && result_ready_i;
    assign w_drain      = w_head_done && r_killed[r_head];
    assign w_free_head  = w_retire || w_drain;

    // Outputs are gated so they read zero whenever nothing is presented.
    assign result_valid_o  = w_head_valid;
    assign result_id_o     = w_head_valid ? r_id[r_head]     : '0;
    assign result_rd_o     = w_head_valid ? r_rd[r_head]     : '0;
    assign result_we_o     = w_head_valid ? r_we[r_head]     : 1'b0;
    assign result_data_o   = w_head_valid ? r_data[r_head]   : '0;
    assign result_fflags_o = w_head_valid ? r_fflags[r_head] : '0;

    always_comb begin
        w_count_nxt = r_count;
        if (w_alloc && !w_free_head) begin
            w_count_nxt = r_count + (TAG_WIDTH+1)'(1);
        end else if (!w_alloc && w_free_head) begin
            w_count_nxt = r_count - (TAG_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i]  <= S_FREE;
                r_killed[i] <= 1'b0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            // Later assignments win: alloc and head-free clear the kill that flush would set.
            for (int i = 0; i < DEPTH; i++) begin
                if (flush_i && (r_state[i] != S_FREE)) begin
                    r_killed[i] <= 1'b1;
                end
                if (w_wb_ok && (fpu_tag_i == TAG_WIDTH'(i))) begin
                    r_state[i] <= S_DONE;
                end
                if (w_free_head && (r_head == TAG_WIDTH'(i))) begin
                    r_state[i]  <= S_FREE;
                    r_killed[i] <= 1'b0;
                end
                if (w_alloc && (r_tail == TAG_WIDTH'(i))) begin
                    r_state[i]  <= S_PEND;
                    r_killed[i] <= 1'b0;
                end
            end
            if (w_alloc) begin
                r_tail <= r_tail + TAG_WIDTH'(1);
            end
            if (w_free_head) begin
                r_head <= r_head + TAG_WIDTH'(1);
            end
            r_count <= w_count_nxt;
            if (w_wb_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset; it is only visible through the gated outputs.
    always_ff @(posedge clk_i) begin
        if (w_alloc) begin
            r_id[r_tail] <= alloc_id_i;
            r_rd[r_tail] <= alloc_rd_i;
            r_we[r_tail] <= alloc_we_i;
        end
        if (w_wb_ok) begin
            r_data[fpu_tag_i]   <= fpu_result_i;
            r_fflags[fpu_tag_i] <= fpu_status_i;
        end
    end

endmodule

// File: tb/tb_cv32e40p_fpu_rob.sv
// Scoreboard bench for cv32e40p_fpu_rob: expected results are queued at allocation
// and compared in order whenever the buffer retires one.
module tb_cv32e40p_fpu_rob;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alloc_valid_i;
    logic        alloc_ready_o;
    logic [3:0]  alloc_id_i;
    logic [4:0]  alloc_rd_i;
    logic        alloc_we_i;
    logic [1:0]  alloc_tag_o;
    logic        fpu_valid_i;
    logic        fpu_ready_o;
    logic [1:0]  fpu_tag_i;
    logic [31:0] fpu_result_i;
    logic [4:0]  fpu_status_i;
    logic        flush_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_fflags_o;
    logic [2:0]  occupancy_o;
    logic        err_o;

    cv32e40p_fpu_rob #(.FLEN(32), .DEPTH(4), .ID_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_id_i(alloc_id_i), .alloc_rd_i(alloc_rd_i), .alloc_we_i(alloc_we_i),
        .alloc_tag_o(alloc_tag_o),
        .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o), .fpu_tag_i(fpu_tag_i),
        .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
        .flush_i(flush_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
        .result_data_o(result_data_o), .result_fflags_o(result_fflags_o),
        .occupancy_o(occupancy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic [4:0]  ff;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_rv   = 0;
    int   m_tail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dat(input int id);
        return 32'hC0DE_0000 + 32'(id) * 32'h0000_0101;
    endfunction

    function automatic logic [4:0] ffl(input int id);
        return 5'(id * 3);
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_alloc(input int id, input logic [31:0] d, input logic [4:0] ff, input bit keep);
        exp_t e;
        alloc_valid_i = 1'b1;
        alloc_id_i    = 4'(id);
        alloc_rd_i    = 5'(id + 1);
        alloc_we_i    = id[0];
        @(negedge clk_i);
        chk("alloc_ready", 64'(alloc_ready_o), 64'd1);
        chk("alloc_tag", 64'(alloc_tag_o), 64'(m_tail));
        if (keep) begin
            e.id = 4'(id); e.rd = 5'(id + 1); e.we = id[0]; e.data = d; e.ff = ff;
            sb.push_back(e);
        end
        m_tail = (m_tail + 1) % 4;
        cyc();
        alloc_valid_i = 1'b0;
    endtask

    task automatic do_wb(input int tag, input logic [31:0] d, input logic [4:0] ff);
        fpu_valid_i  = 1'b1;
        fpu_tag_i    = 2'(tag);
        fpu_result_i = d;
        fpu_status_i = ff;
        cyc();
        fpu_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk_i);
            if (occupancy_o == 3'd0 && sb.size() == 0) break;
        end
        chk("drain_occ", 64'(occupancy_o), 64'd0);
        chk("drain_sb", 64'(sb.size()), 64'd0);
        cyc();
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && result_valid_o) begin
            n_rv++;
            if (result_ready_i) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'(result_id_o), 64'hFFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res_id", 64'(result_id_o), 64'(e.id));
                    chk("res_rd", 64'(result_rd_o), 64'(e.rd));
                    chk("res_we", 64'(result_we_o), 64'(e.we));
                    chk("res_data", 64'(result_data_o), 64'(e.data));
                    chk("res_fflags", 64'(result_fflags_o), 64'(e.ff));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv0;
        rst_i = 1'b1; alloc_valid_i = 0; alloc_id_i = 0; alloc_rd_i = 0; alloc_we_i = 0;
        fpu_valid_i = 0; fpu_tag_i = 0; fpu_result_i = 0; fpu_status_i = 0;
        flush_i = 0; result_ready_i = 1'b1;
        cyc(); cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_alloc_ready", 64'(alloc_ready_o), 64'd1);
        chk("rst_alloc_tag", 64'(alloc_tag_o), 64'd0);
        chk("rst_valid", 64'(result_valid_o), 64'd0);
        chk("rst_occ", 64'(occupancy_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_fpu_ready", 64'(fpu_ready_o), 64'd1);
        chk("rst_data", 64'(result_data_o), 64'd0);
        cyc();

        // Out-of-order writeback, in-order retire
        for (int i = 1; i <= 4; i++) do_alloc(i, dat(i), ffl(i), 1'b1);
        @(negedge clk_i);
        chk("full_ready", 64'(alloc_ready_o), 64'd0);
        chk("full_occ", 64'(occupancy_o), 64'd4);
        cyc();
        do_wb(3, dat(4), ffl(4));
        do_wb(1, dat(2), ffl(2));
        fpu_valid_i = 1'b1; fpu_tag_i = 2'd0; fpu_result_i = dat(1); fpu_status_i = ffl(1);
        @(negedge clk_i);
        chk("first_rv_before", 64'(result_valid_o), 64'd0);
        cyc();
        fpu_tag_i = 2'd2; fpu_result_i = dat(3); fpu_status_i = ffl(3);
        @(negedge clk_i);
        chk("first_rv_after", 64'(result_valid_o), 64'd1);
        cyc();
        fpu_valid_i = 1'b0;
        wait_drain(20);

        // Full buffer: alloc blocked in the retire cycle, granted next cycle at old head
        result_ready_i = 1'b0;
        for (int i = 8; i <= 11; i++) do_alloc(i, dat(i), ffl(i), 1'b1);
        do_wb(0, dat(8), ffl(8));
        @(negedge clk_i);
        chk("held_head_id", 64'(result_id_o), 64'd8);
        cyc();
        alloc_valid_i = 1'b1; alloc_id_i = 4'd12; alloc_rd_i = 5'd13; alloc_we_i = 1'b0;
        result_ready_i = 1'b1;
        @(negedge clk_i);
        chk("full_retire_ready", 64'(alloc_ready_o), 64'd0);
        cyc();
        @(negedge clk_i);
        chk("after_retire_ready", 64'(alloc_ready_o), 64'd1);
        chk("after_retire_tag", 64'(alloc_tag_o), 64'd0);
        sb.push_back('{id: 4'd12, rd: 5'd13, we: 1'b0, data: dat(12), ff: ffl(12)});
        m_tail = 1;
        cyc();
        alloc_valid_i = 1'b0;
        do_wb(1, dat(9), ffl(9));
        do_wb(2, dat(10), ffl(10));
        do_wb(3, dat(11), ffl(11));
        do_wb(0, dat(12), ffl(12));
        wait_drain(20);

        // Flush of two pending entries: silent drain
        do_alloc(5, dat(5), ffl(5), 1'b0);
        do_alloc(6, dat(6), ffl(6), 1'b0);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        rv0 = n_rv;
        do_wb(2, dat(6), ffl(6));
        do_wb(1, dat(5), ffl(5));
        wait_drain(20);
        chk("flush_no_valid", 64'(n_rv - rv0), 64'd0);
        chk("flush_err", 64'(err_o), 64'd0);

        // Flush coincident with a new allocation
        do_alloc(5, dat(5), ffl(5), 1'b0);
        do_alloc(6, dat(6), ffl(6), 1'b0);
        alloc_valid_i = 1'b1; alloc_id_i = 4'd7; alloc_rd_i = 5'd8; alloc_we_i = 1'b1;
        flush_i = 1'b1;
        @(negedge clk_i);
        chk("flush_alloc_tag", 64'(alloc_tag_o), 64'(m_tail));
        sb.push_back('{id: 4'd7, rd: 5'd8, we: 1'b1, data: dat(7), ff: ffl(7)});
        m_tail = (m_tail + 1) % 4;
        cyc();
        alloc_valid_i = 1'b0; flush_i = 1'b0;
        rv0 = n_rv;
        do_wb(1, dat(7), ffl(7));
        do_wb(0, dat(6), ffl(6));
        do_wb(3, dat(5), ffl(5));
        wait_drain(20);
        chk("flush_alloc_one_valid", 64'(n_rv - rv0), 64'd1);

        // Writeback to a FREE tag
        do_wb(2, 32'hDEADBEEF, 5'd0);
        @(negedge clk_i);
        chk("err_set", 64'(err_o), 64'd1);
        chk("err_occ", 64'(occupancy_o), 64'd0);
        chk("err_valid", 64'(result_valid_o), 64'd0);
        chk("err_tail", 64'(alloc_tag_o), 64'd2);
        cyc(); cyc(); cyc();
        do_alloc(13, dat(13), ffl(13), 1'b1);
        do_wb(2, dat(13), ffl(13));
        wait_drain(20);
        chk("err_sticky", 64'(err_o), 64'd1);
        rst_i = 1'b1;
        cyc(); cyc();
        rst_i = 1'b0;
        m_tail = 0;
        @(negedge clk_i);
        chk("err_cleared", 64'(err_o), 64'd0);
        chk("reset_tag", 64'(alloc_tag_o), 64'd0);
        cyc();

        // Backpressure: head held stable for five cycles
        result_ready_i = 1'b0;
        do_alloc(14, dat(14), 5'b00001, 1'b1);
        do_wb(0, dat(14), 5'b00001);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            chk("hold_valid", 64'(result_valid_o), 64'd1);
            chk("hold_id", 64'(result_id_o), 64'd14);
            chk("hold_data", 64'(result_data_o), 64'(dat(14)));
            chk("hold_fflags", 64'(result_fflags_o), 64'd1);
            cyc();
        end
        result_ready_i = 1'b1;
        cyc();
        @(negedge clk_i);
        chk("hold_retired_valid", 64'(result_valid_o), 64'd0);
        chk("hold_retired_occ", 64'(occupancy_o), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
